// File: rtl/fp_alu_scheduler.sv
// Purpose : round-robin arbiter/sequencer sharing one combinational FP16 ALU among NUM_REQ requesters.
// Latency : request handshake -> rsp_valid after L+1 cycles (L = ADD_CYCLES/MUL_CYCLES), 1 cycle for bad opcode.
// Backpr. : one op in flight; no grant until the owner accepts the response, result held stable meanwhile.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             per-requester request handshake (ready one-hot, IDLE only)
//   req_op1/req_op2/req_alu_op      packed per-requester operands (16b) and opcode (4b)
//   rsp_valid/rsp_ready             per-requester response handshake (valid one-hot)
//   rsp_result/rsp_zero/rsp_err     registered response payload
//   alu_op1/alu_op2/alu_op          to shared ALU, held stable during EXEC, zero otherwise
//   alu_result/alu_zero             from shared ALU
//   busy                            high whenever not IDLE
module fp_alu_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int ADD_CYCLES = 1,
    parameter int MUL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_op1,
    input  logic [16*NUM_REQ-1:0]  req_op2,
    input  logic [4*NUM_REQ-1:0]   req_alu_op,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [15:0]            rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_err,
    output logic [15:0]            alu_op1,
    output logic [15:0]            alu_op2,
    output logic [3:0]             alu_op,
    input  logic [15:0]            alu_result,
    input  logic                   alu_zero,
    output logic                   busy
);

    localparam logic [3:0] OP_FADD = 4'b1001;
    localparam logic [3:0] OP_FSUB = 4'b1010;
    localparam logic [3:0] OP_FMUL = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t       state_q, state_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]   owner_q, owner_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [15:0]  op1_q, op1_d;
    logic [15:0]  op2_q, op2_d;
    logic [3:0]   op_q, op_d;
    logic [15:0]  result_q, result_d;
    logic         zero_q, zero_d;
    logic         err_q, err_d;

    logic               grant_vld;
    logic [1:0]         grant;
    logic [NUM_REQ-1:0] grant_mask;
    logic [2:0]         cand;
    logic [NUM_REQ-1:0] cand_mask;
    logic [15:0]        g_op1, g_op2;
    logic [3:0]         g_op;
    logic               owner_rsp_rdy;

    // Scan candidates from the farthest to the nearest of rr_ptr so the last
    // hit (nearest upward from rr_ptr, modulo NUM_REQ) wins.
    always_comb begin
        grant_vld  = 1'b0;
        grant      = '0;
        grant_mask = '0;
        cand       = '0;
        cand_mask  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            cand_mask = NUM_REQ'(1) << cand;
            if (|(req_valid & cand_mask)) begin
                grant_vld  = 1'b1;
                grant      = cand[1:0];
                grant_mask = cand_mask;
            end
        end
    end

    always_comb begin
        g_op1 = '0;
        g_op2 = '0;
        g_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == 2'(i)) begin
                g_op1 = req_op1[16*i +: 16];
                g_op2 = req_op2[16*i +: 16];
                g_op  = req_alu_op[4*i +: 4];
            end
        end
    end

    assign rsp_valid     = (state_q == S_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    // Only the owner's rsp_ready bit survives the mask; others are ignored.
    assign owner_rsp_rdy = |(rsp_ready & rsp_valid);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready = grant_mask;
                    op1_d     = g_op1;
                    op2_d     = g_op2;
                    op_d      = g_op;
                    owner_d   = grant;
                    rr_ptr_d  = (grant == 2'(NUM_REQ - 1)) ? 2'd0 : grant + 2'd1;
                    if (g_op == OP_FADD || g_op == OP_FSUB) begin
                        cnt_d   = 3'(ADD_CYCLES - 1);
                        state_d = S_EXEC;
                    end else if (g_op == OP_FMUL) begin
                        cnt_d   = 3'(MUL_CYCLES - 1);
                        state_d = S_EXEC;
                    end else begin
                        // Bad opcode never touches the ALU.
                        result_d = '0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == 3'd0) begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (owner_rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    // ALU inputs are gated to zero outside EXEC so the multi-cycle path only
    // ever sees values that are stable for the whole EXEC window.
    assign alu_op1    = (state_q == S_EXEC) ? op1_q : '0;
    assign alu_op2    = (state_q == S_EXEC) ? op2_q : '0;
    assign alu_op     = (state_q == S_EXEC) ? op_q  : '0;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_alu_scheduler.sv
module tb_fp_alu_scheduler;

    localparam int N     = 2;
    localparam int ADD_L = 1;
    localparam int MUL_L = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_op1 = '0;
    logic [16*N-1:0]   req_op2 = '0;
    logic [4*N-1:0]    req_alu_op = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '1;
    logic [15:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic [15:0]       alu_op1, alu_op2;
    logic [3:0]        alu_op;
    logic [15:0]       alu_result;
    logic              alu_zero;
    logic              busy;

    always #5 clk = ~clk;

    // Stub ALU: integer add, zero flag ignores the sign bit.
    assign alu_result = alu_op1 + alu_op2;
    assign alu_zero   = (alu_result[14:0] == 15'd0);

    fp_alu_scheduler #(.NUM_REQ(N), .ADD_CYCLES(ADD_L), .MUL_CYCLES(MUL_L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_alu_op(req_alu_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          n_chk = 0;
    int          n_fail = 0;

    // reference-model state (monitor)
    bit          m_busy = 0;
    int          m_owner = 0;
    int          m_ptr = 0;
    int          m_wait = 0;
    int          m_g;
    logic [3:0]  m_op;
    logic [15:0] m_op1, m_op2;
    logic [15:0] last_res;
    logic        last_z, last_e;

    // driver controls
    bit          rand_mode = 0;
    logic [N-1:0] keep = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: condition not reached at %0t", name, $time);
    endtask

    function automatic bit supported(input logic [3:0] op);
        return (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011);
    endfunction

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((32'(v) >> i) & 32'd1) != 32'd0;
    endfunction

    // Monitor: predicts grants/timing from the rules and checks every cycle;
    // pops the scoreboard on a response handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_alu_op", 32'(alu_op), 32'd0);
                m_busy = 0;
                m_ptr  = 0;
                m_wait = 0;
            end else if (!m_busy) begin
                m_g = -1;
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && bit_of(req_valid, (m_ptr + k) % N)) m_g = (m_ptr + k) % N;
                end
                chk("idle_req_ready", 32'(req_ready), (m_g < 0) ? 32'd0 : (32'd1 << m_g));
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("idle_alu_op", {16'(alu_op1), 12'(alu_op2), alu_op}, 32'd0);
                if (m_g >= 0) begin
                    m_busy  = 1;
                    m_owner = m_g;
                    m_ptr   = (m_g + 1) % N;
                    m_op    = 4'(req_alu_op >> (4 * m_g));
                    m_op1   = 16'(req_op1 >> (16 * m_g));
                    m_op2   = 16'(req_op2 >> (16 * m_g));
                    m_wait  = !supported(m_op) ? 0 : (m_op == 4'b1011) ? MUL_L : ADD_L;
                    grant_log.push_back(m_g);
                end
            end else begin
                chk("busy_req_ready", 32'(req_ready), 32'd0);
                chk("busy_flag", 32'(busy), 32'd1);
                if (m_wait > 0) begin
                    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
                    chk("exec_alu_op", 32'(alu_op), 32'(m_op));
                    chk("exec_alu_op1", 32'(alu_op1), 32'(m_op1));
                    chk("exec_alu_op2", 32'(alu_op2), 32'(m_op2));
                    m_wait--;
                end else begin
                    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1 << m_owner);
                    chk("resp_alu_op", 32'(alu_op), 32'd0);
                    if (sb.size() == 0) begin
                        fail_now("resp_scoreboard_empty");
                    end else begin
                        chk("rsp_result", 32'(rsp_result), 32'(sb[0].res));
                        chk("rsp_zero", 32'(rsp_zero), 32'(sb[0].z));
                        chk("rsp_err", 32'(rsp_err), 32'(sb[0].e));
                        if (bit_of(rsp_ready, m_owner)) begin
                            last_res = rsp_result;
                            last_z   = rsp_zero;
                            last_e   = rsp_err;
                            void'(sb.pop_front());
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic load_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        req_op1[16*i +: 16]  = a;
        req_op2[16*i +: 16]  = b;
        req_alu_op[4*i +: 4] = op;
        req_valid[i]         = 1'b1;
    endtask

    task automatic load_rand(input int i);
        logic [15:0] a, b;
        logic [3:0]  op;
        case ($urandom_range(0, 5))
            0, 1:    op = 4'b1001;
            2:       op = 4'b1010;
            3, 4:    op = 4'b1011;
            default: op = 4'($urandom);
        endcase
        a = 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? 16'h8000 - a : 16'($urandom);
        load_req(i, a, b, op);
    endtask

    // One clock of stimulus: record handshakes (expected response pushed at
    // issue time), then update inputs just after the rising edge.
    task automatic cycle();
        logic [N-1:0] hs;
        logic [15:0]  a, b, s;
        logic [3:0]   op;
        exp_t         e;
        @(negedge clk);
        hs = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (bit_of(hs, i)) begin
                a  = 16'(req_op1 >> (16 * i));
                b  = 16'(req_op2 >> (16 * i));
                op = 4'(req_alu_op >> (4 * i));
                s  = a + b;
                e.res = supported(op) ? s : 16'h0000;
                e.z   = supported(op) ? (s[14:0] == 15'd0) : 1'b1;
                e.e   = !supported(op);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (bit_of(hs, i)) begin
                if (bit_of(keep, i)) load_rand(i);
                else req_valid[i] = 1'b0;
            end else if (rand_mode && !bit_of(req_valid, i) && $urandom_range(0, 2) == 0) begin
                load_rand(i);
            end
        end
        if (rand_mode) rsp_ready = N'($urandom);
    endtask

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        load_req(i, a, b, op);
        for (int t = 0; t < 50 && bit_of(req_valid, i); t++) cycle();
        if (bit_of(req_valid, i)) fail_now("issue_timeout");
    endtask

    task automatic wait_done();
        for (int t = 0; t < 80 && (m_busy || req_valid != '0); t++) cycle();
        if (m_busy || req_valid != '0) fail_now("done_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        sb.delete();
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_alu", {16'(alu_op1), 12'(alu_op2), alu_op}, 32'd0);
        chk("async_rst_rsp", {15'd0, rsp_result, rsp_zero}, 32'd0);
        chk("async_rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp", {15'd0, rsp_result, rsp_zero}, 32'd0);
        chk("reset_err_busy", {30'd0, rsp_err, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // single FADD
        rsp_ready = 2'b11;
        issue(0, 16'h3C00, 16'h4000, 4'b1001);
        wait_done();
        chk("fadd_result", 32'(last_res), 32'h7C00);
        chk("fadd_flags", {30'd0, last_z, last_e}, 32'd0);

        // FMUL latency on requester 1
        issue(1, 16'h0001, 16'h0002, 4'b1011);
        wait_done();
        chk("fmul_result", 32'(last_res), 32'h0003);

        // unsupported opcode
        issue(0, 16'h1234, 16'h5678, 4'b0110);
        wait_done();
        chk("bad_op_result", 32'(last_res), 32'h0000);
        chk("bad_op_flags", {30'd0, last_z, last_e}, 32'd3);

        // round-robin with both requesters continuously valid
        do_reset();
        grant_log.delete();
        keep = 2'b11;
        load_rand(0);
        load_rand(1);
        for (int t = 0; t < 60 && grant_log.size() < 4; t++) cycle();
        keep = 2'b00;
        wait_done();
        if (grant_log.size() < 4) fail_now("rr_grants");
        else chk("rr_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]}, 32'h00010001);

        // back-pressure on requester 0, requester 1 pending and its ready high
        rsp_ready = 2'b10;
        issue(0, 16'h1111, 16'h2222, 4'b1001);
        for (int t = 0; t < 20 && !rsp_valid[0]; t++) cycle();
        load_rand(1);
        repeat (5) cycle();
        chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
        chk("bp_no_grant", 32'(req_ready), 32'd0);
        rsp_ready = 2'b11;
        wait_done();

        // randomized traffic with random response back-pressure
        rand_mode = 1;
        repeat (400) cycle();
        rand_mode = 0;
        rsp_ready = 2'b11;
        wait_done();

        // reset in the middle of an FMUL; next grant must go to requester 0
        issue(0, 16'h0100, 16'h0200, 4'b1011);
        cycle();
        chk("mid_fmul_busy", 32'(busy), 32'd1);
        do_reset();
        repeat (3) cycle();
        grant_log.delete();
        load_rand(0);
        load_rand(1);
        for (int t = 0; t < 10 && grant_log.size() < 1; t++) cycle();
        if (grant_log.size() < 1) fail_now("post_reset_grant");
        else chk("post_reset_grant", 32'(grant_log[0]), 32'd0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
